sr_drive_ctrl: RTL and testbench



---
 rtl/sr_drive_ctrl.sv | 148 ++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
// Drives set/reset pulses into a downstream SR latch from debounced raw requests, then checks that q agrees.
// Latency: s or r first high 2 + DEBOUNCE_CYCLES + 1 edges after the raw request settles; check result one edge after the pulse ends.
// Backpressure: none; any request event that arrives while busy is discarded and flagged with dropped.
module sr_drive_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PULSE_CYCLES    = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic q,
   output logic s,
   output logic r,
   output logic busy,
   output logic done,
   output logic err,
   output logic conflict,
   output logic dropped
);

   localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SET_PULSE = 2'd1,
      CLR_PULSE = 2'd2,
      CHECK     = 2'd3
   } state_t;

   // bit 0 = set path, bit 1 = clear path
   logic [1:0] sync1, sync2, deb, deb_d;
   logic [7:0] deb_cnt [2];
   logic       set_ev, clr_ev;

   state_t     state, state_nxt;
   logic [3:0] pcnt, pcnt_nxt;
   logic       exp_q, exp_nxt;
   logic       s_nxt, r_nxt, busy_nxt, done_nxt, err_nxt, conflict_nxt, dropped_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         deb   <= '0;
         deb_d <= '0;
         for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
      end else begin
         sync1 <= {clr_req, set_req};
         sync2 <= sync1;
         deb_d <= deb;
         // A sample that agrees with the accepted level restarts the stability count.
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  deb[i]     <= sync2[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 8'd1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
         end
      end
   end

   assign set_ev = deb[0] & ~deb_d[0];
   assign clr_ev = deb[1] & ~deb_d[1];

   always_comb begin
      state_nxt    = state;
      pcnt_nxt     = pcnt;
      exp_nxt      = exp_q;
      done_nxt     = 1'b0;
      err_nxt      = err;
      conflict_nxt = 1'b0;
      dropped_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (set_ev && !clr_ev) begin
               state_nxt = SET_PULSE;
               pcnt_nxt  = '0;
            end else if (clr_ev && !set_ev) begin
               state_nxt = CLR_PULSE;
               pcnt_nxt  = '0;
            end else if (set_ev && clr_ev) begin
               conflict_nxt = 1'b1;
            end
         end
         SET_PULSE: begin
            if (pcnt == PULSE_LAST) begin
               state_nxt = CHECK;
               exp_nxt   = 1'b1;
            end else begin
               pcnt_nxt = pcnt + 4'd1;
            end
         end
         CLR_PULSE: begin
            if (pcnt == PULSE_LAST) begin
               state_nxt = CHECK;
               exp_nxt   = 1'b0;
            end else begin
               pcnt_nxt = pcnt + 4'd1;
            end
         end
         CHECK: begin
            if (q == exp_q) done_nxt = 1'b1;
            else            err_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (state != IDLE && (set_ev || clr_ev)) dropped_nxt = 1'b1;
      // Drives are decoded from the next state so they leave the flops clean.
      s_nxt    = (state_nxt == SET_PULSE);
      r_nxt    = (state_nxt == CLR_PULSE);
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pcnt     <= '0;
         exp_q    <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         conflict <= 1'b0;
         dropped  <= 1'b0;
      end else begin
         state    <= state_nxt;
         pcnt     <= pcnt_nxt;
         exp_q    <= exp_nxt;
         s        <= s_nxt;
         r        <= r_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         err      <= err_nxt;
         conflict <= conflict_nxt;
         dropped  <= dropped_nxt;
      end
   end

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Directed bench for sr_drive_ctrl with a behavioural SR latch closing the q loop.
module tb_sr_drive_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic set_req = 1'b0;
   logic clr_req = 1'b0;
   logic q;
   logic s, r, busy, done, err, conflict, dropped;

   logic q_lat  = 1'b0;
   logic q_tie0 = 1'b0;

   int total = 0;
   int bad   = 0;

   // output vector bit order: {s, r, busy, done, err, conflict, dropped}
   localparam logic [6:0] O_S = 7'b1000000;
   localparam logic [6:0] O_R = 7'b0100000;
   localparam logic [6:0] O_B = 7'b0010000;
   localparam logic [6:0] O_D = 7'b0001000;
   localparam logic [6:0] O_E = 7'b0000100;
   localparam logic [6:0] O_C = 7'b0000010;
   localparam logic [6:0] O_P = 7'b0000001;

   typedef struct {
      logic       rst;
      logic       set;
      logic       clr;
      logic [6:0] want;
   } vec_t;

   vec_t tbl [16];

   sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .set_req  (set_req),
      .clr_req  (clr_req),
      .q        (q),
      .s        (s),
      .r        (r),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .conflict (conflict),
      .dropped  (dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (s)      q_lat <= 1'b1;
      else if (r) q_lat <= 1'b0;
   end
   assign q = q_tie0 ? 1'b0 : q_lat;

   function automatic logic [6:0] obs();
      return {s, r, busy, done, err, conflict, dropped};
   endfunction

   always @(negedge clk) begin
      total++;
      if (s && r) begin
         bad++;
         $display("FAIL s_r_exclusive t=%0t s=%b r=%b required not both 1", $time, s, r);
      end
   end

   task automatic step(input logic rs, input logic st, input logic cl);
      rst     = rs;
      set_req = st;
      clr_req = cl;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [6:0] want);
      total++;
      if (obs() !== want) begin
         bad++;
         $display("FAIL %s t=%0t got={s,r,busy,done,err,conf,drop}=%b required=%b", nm, $time, obs(), want);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s t=%0t got=%b required=%b", nm, $time, got, want);
      end
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk("reset_state", 7'b0);
   endtask

   initial begin
      int n_conf, n_drop, n_done, n_r;

      // Set path: edge 0 is reset, set_req high before edge 1.
      tbl[0] = '{1'b1, 1'b0, 1'b0, 7'b0};
      for (int i = 1; i <= 6; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 7'b0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, O_S | O_B};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, O_S | O_B};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, O_B};
      tbl[10] = '{1'b0, 1'b1, 1'b0, O_D};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 7'b0};
      for (int i = 12; i < 16; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 7'b0};

      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].rst, tbl[i].set, tbl[i].clr);
         chk($sformatf("set_path_edge%0d", i), tbl[i].want);
      end

      // Bounce: two cycles high, two low, never stable long enough.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step(1'b0, (i < 20) ? ((i / 2) % 2 == 0) : 1'b0, 1'b0);
         chk($sformatf("bounce_cyc%0d", i), 7'b0);
      end

      // Conflict: both requests rise together and stay high.
      do_reset();
      n_conf = 0;
      for (int i = 1; i <= 14; i++) begin
         step(1'b0, 1'b1, 1'b1);
         chk($sformatf("conflict_edge%0d", i), (i == 7) ? O_C : 7'b0);
         if (conflict) n_conf++;
      end
      chk1("conflict_pulse_count_is_1", n_conf == 1, 1'b1);

      // Drop: clear event lands while the set pulse is in progress.
      do_reset();
      n_drop = 0;
      n_done = 0;
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, (i >= 2));
         chk1($sformatf("drop_r_low_edge%0d", i), r, 1'b0);
         chk1($sformatf("drop_pulse_edge%0d", i), dropped, (i == 8));
         if (dropped) n_drop++;
         if (done) n_done++;
      end
      chk1("drop_pulse_count_is_1", n_drop == 1, 1'b1);
      chk1("drop_set_done_count_is_1", n_done == 1, 1'b1);

      // Mismatch: q stuck low, set fails, later clear succeeds with err kept.
      do_reset();
      q_tie0 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (i == 10) chk("mismatch_set_check", O_E);
      end
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b0, 1'b0);
         chk1($sformatf("mismatch_err_sticky_idle%0d", i), err, 1'b1);
      end
      n_done = 0;
      n_r    = 0;
      for (int i = 1; i <= 12; i++) begin
         step(1'b0, 1'b0, 1'b1);
         if (i == 7)  chk("mismatch_clr_pulse", O_R | O_B | O_E);
         if (i == 10) chk("mismatch_clr_done", O_D | O_E);
         chk1($sformatf("mismatch_err_sticky_clr%0d", i), err, 1'b1);
         if (done) n_done++;
         if (r) n_r++;
      end
      chk1("mismatch_clr_done_count_is_1", n_done == 1, 1'b1);
      chk1("mismatch_clr_r_cycles_is_2", n_r == 2, 1'b1);
      q_tie0 = 1'b0;

      // Reset during the second set-pulse cycle, then held request retriggers.
      do_reset();
      for (int i = 1; i <= 7; i++) step(1'b0, 1'b1, 1'b0);
      chk("rst_midop_first_pulse", O_S | O_B);
      step(1'b1, 1'b1, 1'b0);
      chk("rst_midop_cleared", 7'b0);
      for (int i = 1; i <= 6; i++) begin
         step(1'b0, 1'b1, 1'b0);
         chk($sformatf("rst_midop_quiet_edge%0d", i), 7'b0);
      end
      step(1'b0, 1'b1, 1'b0);
      chk("rst_release_retrigger", O_S | O_B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
